// File: rtl/tanh_pwl_pkg.sv
// Shared constants and types for the piecewise-linear tanh activation stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tanh_pwl_pkg;

  // Fixed-point formats: x is Q3.12, y is Q1.15.
  localparam int X_FRAC    = 12;
  localparam int Y_FRAC    = 15;
  localparam int SEG_BITS  = 4;
  localparam int FRAC_BITS = X_FRAC - 2;   // segment width is 0.25
  localparam int X_SAT     = 16384;        // 4.0 in Q3.12
  localparam int Y_MAX     = 32767;
  localparam int Q_MAX     = 127;

  // ICPT[k] = round(tanh(k/4) * 32768), k = 0..16.
  localparam logic [15:0] ICPT [17] = '{
    16'd0,     16'd8025,  16'd15143, 16'd20813, 16'd24956, 16'd27797,
    16'd29660, 16'd30847, 16'd31589, 16'd32048, 16'd32329, 16'd32501,
    16'd32606, 16'd32670, 16'd32708, 16'd32732, 16'd32746
  };

  // SLOPE[k] = ICPT[k+1] - ICPT[k]; the last entry is never selected.
  localparam logic [15:0] SLOPE [17] = '{
    16'd8025, 16'd7118, 16'd5670, 16'd4143, 16'd2841, 16'd1863,
    16'd1187, 16'd742,  16'd459,  16'd281,  16'd172,  16'd105,
    16'd64,   16'd38,   16'd24,   16'd14,   16'd0
  };

  // Stage-2 decomposition of |x| into segment index and in-segment offset.
  typedef struct packed {
    logic                 neg;
    logic                 sat;
    logic [SEG_BITS-1:0]  seg;
    logic [FRAC_BITS-1:0] frac;
  } seg_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

endpackage

// File: rtl/tanh_pwl_lane.sv
// One lane: int32 accumulator -> requantise -> PWL tanh -> signed int8.
// Latency: fixed 4 cycles, one element per cycle.
// Backpressure: none; the lane never stalls.
module tanh_pwl_lane
  import tanh_pwl_pkg::*;
#(
  parameter int          BIAS_WIDTH    = 32,
  parameter int          WEIGHTS_WIDTH = 8,
  parameter logic [15:0] SCALE_MULT    = 16'd2057,
  parameter int          SCALE_SHIFT   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  input  logic signed [BIAS_WIDTH-1:0]    in_dat,
  output logic                            out_vld,
  output logic signed [WEIGHTS_WIDTH-1:0] out_dat,
  output logic                            out_sat
);

  localparam int PW = 48;
  localparam logic signed [PW-1:0] MULT_S = $signed(PW'(SCALE_MULT));

  logic                  v1, v2, v3;
  logic signed [PW-1:0]  p_c, x1;
  logic [PW-1:0]         a_c;
  seg_t                  seg_c, s2;
  logic [4:0]            seg_i;
  logic [31:0]           prod_c, q_c;
  logic [15:0]           y_c, s3_y;
  logic                  s3_neg, s3_sat;
  logic [WEIGHTS_WIDTH-1:0] qc_c;

  // 48-bit product cannot overflow even for INT32_MIN * 65535.
  assign p_c = PW'(in_dat) * MULT_S;

  // Magnitude/sign split and segment lookup address.
  always_comb begin
    a_c        = x1[PW-1] ? -x1 : x1;
    seg_c.neg  = x1[PW-1];
    seg_c.sat  = (a_c >= PW'(X_SAT));
    seg_c.seg  = a_c[FRAC_BITS +: SEG_BITS];
    seg_c.frac = a_c[FRAC_BITS-1:0];
  end

  // Linear interpolation inside the selected segment, Q1.15.
  always_comb begin
    seg_i  = {1'b0, s2.seg};
    prod_c = 32'(SLOPE[seg_i]) * 32'(s2.frac);
    y_c    = s2.sat ? 16'(Y_MAX) : ICPT[seg_i] + 16'(prod_c >> FRAC_BITS);
  end

  // Round Q1.15 to int8 magnitude and clamp so -128 never appears.
  always_comb begin
    q_c  = (32'(s3_y) * 32'(Q_MAX) + 32'(1 << (Y_FRAC - 1))) >> Y_FRAC;
    qc_c = (q_c > 32'(Q_MAX)) ? WEIGHTS_WIDTH'(Q_MAX) : q_c[WEIGHTS_WIDTH-1:0];
  end

  // Four pipeline registers with valids travelling alongside the data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      out_vld <= 1'b0;
      x1      <= '0;
      s2      <= '0;
      s3_y    <= '0;
      s3_neg  <= 1'b0;
      s3_sat  <= 1'b0;
      out_dat <= '0;
      out_sat <= 1'b0;
    end else begin
      v1      <= in_vld;
      v2      <= v1;
      v3      <= v2;
      out_vld <= v3;
      x1      <= p_c >>> SCALE_SHIFT;
      s2      <= seg_c;
      s3_y    <= y_c;
      s3_neg  <= s2.neg;
      s3_sat  <= s2.sat;
      out_dat <= s3_neg ? -qc_c : qc_c;
      out_sat <= s3_sat;
    end
  end

endmodule

// File: rtl/tanh_pwl_array.sv
// Multi-lane PWL tanh over an INPUT_SIZE vector per start/done transaction.
// Latency: INPUT_SIZE/LANES + 5 cycles from accepted start to done.
// Backpressure: none; start is ignored while busy. Option: TANH_SAT_COUNT_EN adds sat_count.
module tanh_pwl_array
  import tanh_pwl_pkg::*;
#(
  parameter int          INPUT_SIZE    = 512,
  parameter int          LANES         = 8,
  parameter int          WEIGHTS_WIDTH = 8,
  parameter int          BIAS_WIDTH    = 32,
  parameter logic [15:0] SCALE_MULT    = 16'd2057,
  parameter int          SCALE_SHIFT   = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  input  logic signed [BIAS_WIDTH-1:0]    inputs    [INPUT_SIZE],
  output logic signed [WEIGHTS_WIDTH-1:0] layer_out [INPUT_SIZE]
`ifdef TANH_SAT_COUNT_EN
  ,
  output logic [$clog2(INPUT_SIZE+1)-1:0] sat_count
`endif
);

  localparam int GROUPS = INPUT_SIZE / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int IW     = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int LB     = $clog2(LANES);

  if (INPUT_SIZE % LANES != 0) begin : g_size_chk
    $error("INPUT_SIZE must be a multiple of LANES");
  end
  if (LANES < 1 || LANES > 64 || (LANES & (LANES - 1)) != 0) begin : g_lane_chk
    $error("LANES must be a power of two in 1..64");
  end

  state_t                          state, state_d;
  logic                            busy_d, done_d, issue_vld, last_issue, last_write, s4_vld;
  logic [GW-1:0]                   grp, wgrp;
  logic [IW-1:0]                   issue_base, write_base;
  logic [LANES-1:0]                lane_vld, lane_sat;
  logic signed [WEIGHTS_WIDTH-1:0] lane_dat [LANES];

  assign issue_base = IW'(grp) << LB;
  assign write_base = IW'(wgrp) << LB;
  assign last_issue = (grp == GW'(GROUPS - 1));
  assign s4_vld     = &lane_vld;
  assign last_write = s4_vld && (wgrp == GW'(GROUPS - 1));

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    tanh_pwl_lane #(
      .BIAS_WIDTH   (BIAS_WIDTH),
      .WEIGHTS_WIDTH(WEIGHTS_WIDTH),
      .SCALE_MULT   (SCALE_MULT),
      .SCALE_SHIFT  (SCALE_SHIFT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .in_vld (issue_vld),
      .in_dat (inputs[issue_base + IW'(l)]),
      .out_vld(lane_vld[l]),
      .out_dat(lane_dat[l]),
      .out_sat(lane_sat[l])
    );
  end

  // Next-state and issue control; done fires on the final group's write.
  always_comb begin
    state_d   = state;
    issue_vld = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE:  if (start) state_d = RUN;
      RUN: begin
        issue_vld = 1'b1;
        if (last_issue) state_d = DRAIN;
      end
      DRAIN: if (last_write) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, status flags and issue/write group counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      grp   <= '0;
      wgrp  <= '0;
    end else begin
      state <= state_d;
      busy  <= busy_d;
      done  <= done_d;
      if (issue_vld) grp <= last_issue ? '0 : grp + 1'b1;
      if (s4_vld)    wgrp <= last_write ? '0 : wgrp + 1'b1;
    end
  end

  // Output vector: only the group leaving stage 4 is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < INPUT_SIZE; i++) layer_out[i] <= '0;
    end else if (s4_vld) begin
      for (int l = 0; l < LANES; l++) layer_out[write_base + IW'(l)] <= lane_dat[l];
    end
  end

`ifdef TANH_SAT_COUNT_EN
  localparam int CW = $clog2(INPUT_SIZE + 1);
  logic [CW-1:0] sat_sum;

  // Number of saturated elements in the group currently being written.
  always_comb begin
    sat_sum = '0;
    for (int l = 0; l < LANES; l++) sat_sum = sat_sum + CW'(lane_sat[l]);
  end

  // Per-transaction saturation count, held from done until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         sat_count <= '0;
    else if (state == IDLE && start) sat_count <= '0;
    else if (s4_vld)                 sat_count <= sat_count + sat_sum;
  end
`else
  logic sat_unused;
  assign sat_unused = |lane_sat;
`endif

endmodule

// File: tb/tb_tanh_pwl_array.sv
module tb_tanh_pwl_array;

  localparam int N   = 512;
  localparam int L   = 8;
  localparam int LAT = N / L + 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              busy, done;
  logic signed [31:0] inputs    [N];
  logic signed [7:0]  layer_out [N];
`ifdef TANH_SAT_COUNT_EN
  logic [9:0]        sat_count;
`endif

  int passes = 0;
  int total  = 0;
  int exp_out [N];
  int icpt    [17];
  int done_at [$];
  int ndone;

  tanh_pwl_array #(.INPUT_SIZE(N), .LANES(L)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .inputs   (inputs),
    .layer_out(layer_out)
`ifdef TANH_SAT_COUNT_EN
    ,
    .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  // Requantised x in Q3.12 with floor rounding.
  function automatic longint x_of(int v);
    longint p;
    p = longint'(v) * 2057;
    return p >>> 4;
  endfunction

  // Reference PWL tanh built from the real tanh curve.
  function automatic int ref_f(int v);
    longint x, a;
    int y, k, fr, q;
    x = x_of(v);
    a = (x < 0) ? -x : x;
    if (a >= 16384) y = 32767;
    else begin
      k  = int'(a / 1024);
      fr = int'(a % 1024);
      y  = icpt[k] + ((icpt[k+1] - icpt[k]) * fr) / 1024;
    end
    q = (y * 127 + 16384) / 32768;
    if (q > 127) q = 127;
    return (x < 0) ? -q : q;
  endfunction

  function automatic int ref_sat_count();
    int n;
    longint x;
    n = 0;
    for (int i = 0; i < N; i++) begin
      x = x_of(inputs[i]);
      if (x >= 16384 || x <= -16384) n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
  endtask

  task automatic set_expected();
    for (int i = 0; i < N; i++) exp_out[i] = ref_f(inputs[i]);
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) chk(tag, int'(layer_out[i]), exp_out[i]);
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++)
      case (i % 4)
        0:       inputs[i] = $urandom;
        1:       inputs[i] = int'($urandom_range(0, 400)) - 200;
        2:       inputs[i] = 16 * (int'($urandom_range(0, 24)) - 12);
        default: inputs[i] = -inputs[i-1];
      endcase
  endtask

  // Pulse or hold start, optionally re-assert it, and log every done pulse.
  task automatic run_txn(input int hold, input int reassert_at, input bit b2b, input int budget);
    done_at.delete();
    start = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (c == 1)  chk("busy_after_start", int'(busy), 1);
      if (c == 10) chk("retain_old", int'(layer_out[N-1]), exp_out[N-1]);
      if (done) done_at.push_back(c);
      start = (c < hold) || (c == reassert_at) ||
              (b2b && done_at.size() == 1 && c == done_at[0] + 1);
    end
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k <= 16; k++) icpt[k] = int'($floor($tanh(k / 4.0) * 32768.0 + 0.5));
    for (int i = 0; i < N; i++) begin
      inputs[i]  = 0;
      exp_out[i] = 0;
    end

    // Reset state
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out0", int'(layer_out[0]), 0);
    chk("rst_outN", int'(layer_out[N-1]), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // All-zero vector and start-to-done latency
    run_txn(1, 0, 0, 100);
    chk("zero_ndone", done_at.size(), 1);
    if (done_at.size() > 0) chk("zero_latency", done_at[0], LAT);
    chk("zero_busy_end", int'(busy), 0);
    set_expected();
    check_all("zero_out");
`ifdef TANH_SAT_COUNT_EN
    chk("zero_satcnt", int'(sat_count), 0);
`endif

    // Alternating +/-1000: saturation both ways
    for (int i = 0; i < N; i++) inputs[i] = (i % 2 == 0) ? 1000 : -1000;
    run_txn(1, 0, 0, 100);
    chk("sat_ndone", done_at.size(), 1);
    chk("sat_pos", int'(layer_out[0]), 127);
    chk("sat_neg", int'(layer_out[1]), -127);
    set_expected();
    check_all("sat_out");
`ifdef TANH_SAT_COUNT_EN
    chk("sat_satcnt", int'(sat_count), 512);
`endif

    // Sweep -200..200 plus extreme and reference points
    for (int i = 0; i < N; i++) inputs[i] = (i < 401) ? i - 200 : int'($urandom);
    inputs[401] = 16;
    inputs[402] = 32'sh7FFFFFFF;
    inputs[403] = 32'sh80000000;
    inputs[404] = -16;
    run_txn(1, 0, 0, 100);
    chk("sweep_ndone", done_at.size(), 1);
    chk("in_16", int'(layer_out[401]), 59);
    chk("in_max", int'(layer_out[402]), 127);
    chk("in_min", int'(layer_out[403]), -127);
    chk("in_m16", int'(layer_out[404]), -59);
    chk("in_0", int'(layer_out[200]), 0);
    set_expected();
    check_all("sweep_out");
`ifdef TANH_SAT_COUNT_EN
    chk("sweep_satcnt", int'(sat_count), ref_sat_count());
`endif
    for (int v = -200; v <= 200; v++) begin
      real xr;
      int  ideal, d;
      xr    = real'(x_of(v)) / 4096.0;
      ideal = int'($floor(127.0 * $tanh(xr) + 0.5));
      d     = ref_f(v) - ideal;
      chk("model_tol", int'(d >= -1 && d <= 1), 1);
    end

    // Random vector with exact mirrored pairs
    rand_inputs();
    run_txn(1, 0, 0, 100);
    set_expected();
    check_all("rand_out");
    for (int i = 3; i < N; i += 4) chk("symmetry", int'(layer_out[i]), -int'(layer_out[i-1]));
`ifdef TANH_SAT_COUNT_EN
    chk("rand_satcnt", int'(sat_count), ref_sat_count());
`endif

    // start held 3 cycles and re-asserted mid-RUN: one transaction only
    rand_inputs();
    run_txn(3, 20, 0, 120);
    chk("hold_ndone", done_at.size(), 1);
    if (done_at.size() > 0) chk("hold_latency", done_at[0], LAT);
    set_expected();
    check_all("hold_out");

    // Second start on the cycle after done
    rand_inputs();
    run_txn(1, 0, 1, 200);
    chk("b2b_ndone", done_at.size(), 2);
    if (done_at.size() > 0) chk("b2b_latency1", done_at[0], LAT);
    if (done_at.size() > 1) chk("b2b_gap", done_at[1] - done_at[0], LAT + 1);
    set_expected();
    check_all("b2b_out");
`ifdef TANH_SAT_COUNT_EN
    chk("b2b_satcnt", int'(sat_count), ref_sat_count());
`endif

    // Reset 20 cycles into RUN aborts and clears
    rand_inputs();
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    for (int i = 0; i < N; i++) exp_out[i] = 0;
    check_all("abort_clear");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ndone = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", int'(busy), 0);

    // Normal completion after the abort
    rand_inputs();
    run_txn(1, 0, 0, 100);
    chk("post_ndone", done_at.size(), 1);
    if (done_at.size() > 0) chk("post_latency", done_at[0], LAT);
    set_expected();
    check_all("post_out");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
